// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants, FSM state and beat type for the PE datapath
//
// Purpose: common definitions for the PE and its operand feeder.
//   KSIZE        kernel side (window is KSIZE*KSIZE beats)
//   PIC_W/WGT_W  pixel / weight operand widths
//   ACC_W        PE accumulator width
//   state_e      feeder FSM states
//   beat_t       one pixel/weight pair plus window framing markers
// Ports: none (package).

package pe_pkg;

  localparam int KSIZE = 5;
  localparam int PIC_W = 16;
  localparam int WGT_W = 16;
  localparam int ACC_W = 37;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [PIC_W-1:0] pic;
    logic [WGT_W-1:0] wgt;
    logic             first;
    logic             last;
  } beat_t;

endpackage

// File: rtl/pe_skid_fifo.sv
// rtl/pe_skid_fifo.sv - 2-entry fall-through skid FIFO for PE operand beats
//
// Purpose: buffers up to two beats between the SRAM read pipe and the PE.
// When empty, the incoming beat is presented on the output in the same
// cycle, so an unstalled stream sees no extra latency.
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_in_valid/o_in_ready/i_in_data    write side
//   o_out_valid/i_out_ready/o_out_data head side
//   o_count                         number of stored entries (0..2)

module pe_skid_fifo
  import pe_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  T           i_in_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output T           o_out_data,
  output logic [1:0] o_count
);

  T           r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_store;
  logic w_deq;

  assign w_empty     = (r_count == 2'd0);
  assign o_in_ready  = (r_count != 2'd2);
  assign o_out_valid = !w_empty || i_in_valid;
  assign o_out_data  = w_empty ? i_in_data : r_mem[r_rd_ptr];
  assign o_count     = r_count;

  assign w_pop   = o_out_valid && i_out_ready;
  assign w_push  = i_in_valid && o_in_ready;
  // A beat that arrives into an empty FIFO and is taken at once never lands.
  assign w_store = w_push && !(w_empty && w_pop);
  assign w_deq   = w_pop && !w_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_store) begin
        r_mem[r_wr_ptr] <= i_in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_store} - {1'b0, w_deq};
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - fetches one KSIZE x KSIZE window + kernel and streams them to the PE
//
// Purpose: on start, walks the window in raster order, reads the picture and
// weight SRAMs, zero-pads pixels outside the image and streams pixel/weight
// pairs with first/last markers under downstream backpressure.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_start, i_win_row/col       window launch (sampled in IDLE only)
//   o_busy, o_done               window in progress / one-cycle completion pulse
//   o_pic_rd_*, i_pic_rd_dat     picture SRAM port (1-cycle read latency)
//   o_wgt_rd_*, i_wgt_rd_dat     weight SRAM port (1-cycle read latency)
//   o_picDat, o_weightDat        operands to PE
//   o_dat_valid/first/last, i_dat_ready  beat handshake and framing

module pe_feeder
  import pe_pkg::*;
#(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int PADDR_W = 10,
  parameter int WADDR_W = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [$clog2(IMG_H)-1:0] i_win_row,
  input  logic [$clog2(IMG_W)-1:0] i_win_col,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_pic_rd_en,
  output logic [PADDR_W-1:0]       o_pic_rd_addr,
  input  logic [PIC_W-1:0]         i_pic_rd_dat,
  output logic                     o_wgt_rd_en,
  output logic [WADDR_W-1:0]       o_wgt_rd_addr,
  input  logic [WGT_W-1:0]         i_wgt_rd_dat,
  output logic [PIC_W-1:0]         o_picDat,
  output logic [WGT_W-1:0]         o_weightDat,
  output logic                     o_dat_valid,
  output logic                     o_dat_first,
  output logic                     o_dat_last,
  input  logic                     i_dat_ready
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int AW = PADDR_W + 1;
  localparam int KW = $clog2(KSIZE + 1);
  localparam logic [KW-1:0] K_LAST = KW'(KSIZE - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;
  logic [KW-1:0] r_kr;
  logic [KW-1:0] r_kc;
  logic          r_done;

  // Read issued last cycle: its SRAM data is on i_*_rd_dat this cycle.
  logic          r_inf_valid;
  logic          r_inf_pad;
  logic          r_inf_first;
  logic          r_inf_last;

  logic [AW-1:0]      w_row;
  logic [AW-1:0]      w_col;
  logic               w_pad;
  logic [PADDR_W-1:0] w_pic_addr;
  logic [WADDR_W-1:0] w_wgt_addr;
  logic               w_idx_first;
  logic               w_idx_last;
  logic               w_issue;
  logic               w_last_xfer;
  logic [1:0]         w_occ;

  beat_t      w_in_beat;
  beat_t      w_head;
  logic       w_head_valid;
  logic       w_fifo_in_ready;
  logic [1:0] w_fifo_count;

  // Window coordinates widened before the bound check so that columns past
  // the right edge are padded instead of wrapping onto the next row.
  assign w_row      = AW'(r_win_row) + AW'(r_kr);
  assign w_col      = AW'(r_win_col) + AW'(r_kc);
  assign w_pad      = (w_row >= AW'(IMG_H)) || (w_col >= AW'(IMG_W));
  assign w_pic_addr = PADDR_W'(w_row * AW'(IMG_W) + w_col);
  assign w_wgt_addr = WADDR_W'(r_kr) * WADDR_W'(KSIZE) + WADDR_W'(r_kc);

  assign w_idx_first = (r_kr == '0) && (r_kc == '0);
  assign w_idx_last  = (r_kr == K_LAST) && (r_kc == K_LAST);

  // Stored beats plus the one arriving from SRAM must never exceed the
  // FIFO depth, so every issued read has a guaranteed slot.
  assign w_occ = w_fifo_count + {1'b0, r_inf_valid};

  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    w_last_xfer   = 1'b0;
    o_pic_rd_en   = 1'b0;
    o_pic_rd_addr = '0;
    o_wgt_rd_en   = 1'b0;
    o_wgt_rd_addr = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue = (w_occ < 2'd2) && w_fifo_in_ready;
        if (w_issue && w_idx_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_last_xfer = w_head_valid && i_dat_ready && w_head.last;
        if (w_last_xfer) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_issue) begin
      o_wgt_rd_en   = 1'b1;
      o_wgt_rd_addr = w_wgt_addr;
      if (!w_pad) begin
        o_pic_rd_en   = 1'b1;
        o_pic_rd_addr = w_pic_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_done      <= 1'b0;
      r_inf_valid <= 1'b0;
      r_inf_pad   <= 1'b0;
      r_inf_first <= 1'b0;
      r_inf_last  <= 1'b0;
    end else begin
      r_done <= w_last_xfer;
      if ((r_state == ST_IDLE) && i_start) begin
        r_win_row <= i_win_row;
        r_win_col <= i_win_col;
        r_kr      <= '0;
        r_kc      <= '0;
      end else if (w_issue) begin
        if (r_kc == K_LAST) begin
          r_kc <= '0;
          r_kr <= r_kr + KW'(1);
        end else begin
          r_kc <= r_kc + KW'(1);
        end
      end
      r_inf_valid <= w_issue;
      r_inf_pad   <= w_pad;
      r_inf_first <= w_idx_first;
      r_inf_last  <= w_idx_last;
    end
  end

  always_comb begin
    w_in_beat = '0;
    if (r_inf_valid) begin
      w_in_beat.pic   = r_inf_pad ? '0 : i_pic_rd_dat;
      w_in_beat.wgt   = i_wgt_rd_dat;
      w_in_beat.first = r_inf_first;
      w_in_beat.last  = r_inf_last;
    end
  end

  pe_skid_fifo #(
    .T(beat_t)
  ) u_skid (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_in_valid (r_inf_valid),
    .o_in_ready (w_fifo_in_ready),
    .i_in_data  (w_in_beat),
    .o_out_valid(w_head_valid),
    .i_out_ready(i_dat_ready),
    .o_out_data (w_head),
    .o_count    (w_fifo_count)
  );

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_dat_valid = w_head_valid;
  assign o_picDat    = w_head_valid ? w_head.pic : '0;
  assign o_weightDat = w_head_valid ? w_head.wgt : '0;
  assign o_dat_first = w_head_valid && w_head.first;
  assign o_dat_last  = w_head_valid && w_head.last;

endmodule

// File: tb/tb_pe_feeder.sv
// tb/tb_pe_feeder.sv - self-checking bench for pe_feeder

module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  win_row;
  logic [4:0]  win_col;
  logic        busy;
  logic        done;
  logic        pic_rd_en;
  logic [9:0]  pic_rd_addr;
  logic [15:0] pic_rd_dat;
  logic        wgt_rd_en;
  logic [4:0]  wgt_rd_addr;
  logic [15:0] wgt_rd_dat;
  logic [15:0] picDat;
  logic [15:0] weightDat;
  logic        dat_valid;
  logic        dat_first;
  logic        dat_last;
  logic        dat_ready;

  always #5 clk = ~clk;

  pe_feeder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_win_row    (win_row),
    .i_win_col    (win_col),
    .o_busy       (busy),
    .o_done       (done),
    .o_pic_rd_en  (pic_rd_en),
    .o_pic_rd_addr(pic_rd_addr),
    .i_pic_rd_dat (pic_rd_dat),
    .o_wgt_rd_en  (wgt_rd_en),
    .o_wgt_rd_addr(wgt_rd_addr),
    .i_wgt_rd_dat (wgt_rd_dat),
    .o_picDat     (picDat),
    .o_weightDat  (weightDat),
    .o_dat_valid  (dat_valid),
    .o_dat_first  (dat_first),
    .o_dat_last   (dat_last),
    .i_dat_ready  (dat_ready)
  );

  logic [15:0] pic_mem [1024];
  logic [15:0] wgt_mem [32];

  // Unread cycles return junk so a missing pad gate is visible.
  always @(posedge clk) begin
    pic_rd_dat <= pic_rd_en ? pic_mem[pic_rd_addr] : 16'hDEAD;
    wgt_rd_dat <= wgt_rd_en ? wgt_mem[wgt_rd_addr] : 16'hBEEF;
  end

  int          tests = 0;
  int          fails = 0;
  logic [33:0] sb_q [$];
  int          n_xfer = 0;
  int          cyc = 0;
  int          rmode = 0;
  bit          mon_en = 1'b0;
  logic        exp_done = 1'b0;
  logic        prev_stall = 1'b0;
  logic [33:0] prev_beat = '0;

  wire [33:0] cur_beat = {picDat, weightDat, dat_first, dat_last};
  wire [53:0] all_out  = {busy, done, pic_rd_en, pic_rd_addr, wgt_rd_en, wgt_rd_addr,
                          picDat, weightDat, dat_valid, dat_first, dat_last};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] exp_beat(input int wr, input int wc, input int r, input int c);
    int          row = wr + r;
    int          col = wc + c;
    logic [15:0] p;
    logic [15:0] w;
    p = (row >= 32 || col >= 32) ? 16'd0 : 16'(row * 32 + col);
    w = 16'(r * 5 + c + 1);
    return {p, w, (r == 0 && c == 0), (r == 4 && c == 4)};
  endfunction

  task automatic push_win(input int wr, input int wc);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        sb_q.push_back(exp_beat(wr, wc, r, c));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (rmode)
      1:       dat_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       dat_ready = 1'b0;
      default: dat_ready = 1'b1;
    endcase
  endtask

  task automatic start_win(input int wr, input int wc, input bit accept);
    start   = 1'b1;
    win_row = 5'(wr);
    win_col = 5'(wc);
    if (accept) push_win(wr, wc);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int ncyc, output int npic, output int nwgt);
    ncyc = 0;
    npic = 0;
    nwgt = 0;
    while (!done && ncyc < 400) begin
      npic += int'(pic_rd_en);
      nwgt += int'(wgt_rd_en);
      step();
      ncyc++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic wait_xfers(input int n);
    int base = n_xfer;
    int k = 0;
    while (n_xfer < base + n && k < 200) begin
      step();
      k++;
    end
    check("xfer_reached", 64'(n_xfer - base), 64'(n));
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [33:0] exp;
    if (rst || !mon_en) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      check("done_pulse", 64'(done), 64'(exp_done));
      exp_done = 1'b0;
      if (prev_stall) check("stall_hold", 64'({dat_valid, cur_beat}), 64'({1'b1, prev_beat}));
      if (dat_valid) begin
        if (dat_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(dat_valid), 64'd0);
          end else begin
            exp = sb_q.pop_front();
            check("beat", 64'(cur_beat), 64'(exp));
            n_xfer++;
            exp_done = exp[0];
          end
        end
      end else begin
        check("idle_zero", 64'(cur_beat), 64'd0);
      end
      prev_stall = dat_valid && !dat_ready;
      prev_beat  = cur_beat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nc;
    int np;
    int nw;
    for (int a = 0; a < 1024; a++) pic_mem[a] = 16'(a);
    for (int i = 0; i < 32; i++) wgt_mem[i] = 16'(i + 1);
    rst       = 1'b1;
    start     = 1'b0;
    win_row   = '0;
    win_col   = '0;
    dat_ready = 1'b1;
    repeat (3) step();
    check("reset_outputs", 64'(all_out), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    // 1: interior window, no backpressure
    start_win(2, 3, 1'b1);
    check("s1_busy", 64'(busy), 64'd1);
    check("s1_no_beat_c1", 64'(dat_valid), 64'd0);
    wait_done(nc, np, nw);
    check("s1_cycles", 64'(nc), 64'd26);
    check("s1_busy_low", 64'(busy), 64'd0);
    check("s1_sb_empty", 64'(sb_q.size()), 64'd0);
    step();

    // 2: bottom-right edge padding
    start_win(30, 30, 1'b1);
    wait_done(nc, np, nw);
    check("s2_pic_reads", 64'(np), 64'd4);
    check("s2_wgt_reads", 64'(nw), 64'd25);
    check("s2_cycles", 64'(nc), 64'd26);
    check("s2_sb_empty", 64'(sb_q.size()), 64'd0);
    step();

    // 3: ready pattern 1,0,0,1
    rmode = 1;
    start_win(2, 3, 1'b1);
    wait_done(nc, np, nw);
    check("s3_sb_empty", 64'(sb_q.size()), 64'd0);
    rmode = 0;
    step();

    // 4: start while busy ignored, then back-to-back start in done cycle
    start_win(2, 3, 1'b1);
    wait_xfers(10);
    start   = 1'b1;
    win_row = 5'd7;
    win_col = 5'd9;
    step();
    start = 1'b0;
    wait_done(nc, np, nw);
    check("s4_sb_empty", 64'(sb_q.size()), 64'd0);
    start_win(0, 0, 1'b1);
    check("s4_b2b_busy", 64'(busy), 64'd1);
    step();
    check("s4_b2b_first", 64'({dat_valid, dat_first}), 64'd3);
    wait_done(nc, np, nw);
    check("s4_b2b_sb_empty", 64'(sb_q.size()), 64'd0);
    step();

    // 5: reset mid-window
    start_win(4, 5, 1'b1);
    wait_xfers(12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    check("s5_outputs_zero", 64'(all_out), 64'd0);
    repeat (5) step();
    check("s5_idle", 64'(busy), 64'd0);
    start_win(1, 1, 1'b1);
    wait_done(nc, np, nw);
    check("s5_cycles", 64'(nc), 64'd26);
    check("s5_sb_empty", 64'(sb_q.size()), 64'd0);
    step();

    // 6: stalled downstream right after start
    rmode = 2;
    start_win(3, 4, 1'b1);
    np = 0;
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      np += int'(pic_rd_en);
      nw += int'(wgt_rd_en);
      step();
    end
    check("s6_pic_issues", 64'(np), 64'd2);
    check("s6_wgt_issues", 64'(nw), 64'd2);
    check("s6_valid_held", 64'(dat_valid), 64'd1);
    rmode = 0;
    step();
    wait_done(nc, np, nw);
    check("s6_sb_empty", 64'(sb_q.size()), 64'd0);
    step();

    check("sb_final", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
